jedro_1_test_monitor: RTL and testbench
=======================================

// Module: jedro_1_test_monitor
// PURPOSE
//  Synthesisable end-of-test monitor for jedro_1 directed programs; replaces per-bench polling loops.
//  After start it counts cycles until the core flags an illegal instruction or a cycle limit is hit.
//  It then drains the pipeline and compares NUM_CHECKS register-file entries against expected values.
//  It reports pass/fail, the halt cause and the first mismatch. Sits beside jedro_1_top; taps the decoder and a regfile read port.
// PARAMETERS
//  DATA_WIDTH      32  register data width
//  REG_ADDR_WIDTH  5   register index width
//  MAX_CYCLES      64  run-phase cycle limit (>=1)
//  DRAIN_CYCLES    3   cycles waited after halt before checking (>=0)
//  NUM_CHECKS      2   number of register/value pairs compared (>=1)
//  REQUIRE_HALT    1   1: timeout forces fail; 0: timeout is an acceptable end
// PORTS
//  clk_i               in   1                          clock
//  rstn_i              in   1                          async active-low reset
//  start_i             in   1                          begin a run (honoured in IDLE only)
//  clear_i             in   1                          DONE -> IDLE, clears results
//  illegal_instr_i     in   1                          decoder illegal-instruction flag
//  exp_addr_i          in   NUM_CHECKS*REG_ADDR_WIDTH  packed check register indices, entry k at [k*RAW +: RAW]
//  exp_data_i          in   NUM_CHECKS*DATA_WIDTH      packed expected values
//  reg_addr_o          out  REG_ADDR_WIDTH             regfile read index (combinational read path)
//  reg_data_i          in   DATA_WIDTH                 regfile read data for reg_addr_o, same cycle
//  busy_o              out  1                          state != IDLE && state != DONE
//  done_o              out  1                          high in DONE
//  pass_o              out  1                          valid when done_o
//  halted_o            out  1                          run ended by illegal_instr_i
//  timeout_o           out  1                          run ended by cycle limit
//  fail_count_o        out  $clog2(NUM_CHECKS+1)       number of mismatches
//  first_fail_idx_o    out  $clog2(NUM_CHECKS) (min 1) index of first mismatch
//  first_fail_data_o   out  DATA_WIDTH                 actual value at first mismatch
//  cycle_count_o       out  $clog2(MAX_CYCLES+1)       run cycles consumed
// BEHAVIOUR
//  Reset: all outputs 0; reg_addr_o 0; state IDLE. Assertion mid-run aborts immediately, with no partial results.
//  FSM: IDLE -start_i-> RUN -> DRAIN -> CHECK -> DONE -clear_i-> IDLE.
//  RUN: cycle_count increments each cycle, saturating at MAX_CYCLES.
//   - illegal_instr_i=1 -> halted_o<=1, go to DRAIN.
//   - Otherwise, when cycle_count==MAX_CYCLES-1 -> timeout_o<=1, go to DRAIN.
//   - If both occur in the same cycle, halt wins and timeout_o stays 0.
//  DRAIN: waits exactly DRAIN_CYCLES cycles. DRAIN_CYCLES=0 goes straight to CHECK.
//   - illegal_instr_i is ignored from DRAIN onward.
//  CHECK: one entry per cycle, k=0..NUM_CHECKS-1; reg_addr_o=exp_addr[k].
//   - Compare reg_data_i to exp_data[k] in the same cycle.
//   - On mismatch: fail_count++; on the first mismatch, latch k and reg_data_i.
//   - Duplicate indices and index 0 are checked normally.
//  Entering DONE: pass_o = (fail_count==0) && !(REQUIRE_HALT && timeout_o); done_o=1.
//   - All results hold until clear_i or reset.
//  clear_i is ignored outside DONE. start_i is ignored outside IDLE.
//   - If start_i and clear_i are both high in DONE, clear wins; start must be re-asserted in IDLE.
//  Latency from halt: DRAIN_CYCLES + NUM_CHECKS + 1 cycles to done_o.
//  exp_* must be stable from start through DONE.
// STRUCTURE
//  jedro_1_test_pkg: state enum (IDLE, RUN, DRAIN, CHECK, DONE) and localparam width helpers.
//  No sub-module. Run and drain share one counter; a separate check index, comparator and result registers.
// TESTING (bench wraps jedro_1_top, hooks decoder flag and regfile)
//  1. blt program (x1=0, x2=7), checks {x1:0, x2:7}, illegal at cycle ~20
//     -> halted_o=1, timeout_o=0, pass_o=1, fail_count_o=0.
//  2. Same program, expected x2=8
//     -> pass_o=0, fail_count_o=1, first_fail_idx_o=1, first_fail_data_o=7.
//  3. Program without illegal, MAX_CYCLES=64
//     -> timeout_o=1, cycle_count_o=64; pass_o=0 (REQUIRE_HALT=1) or 1 (REQUIRE_HALT=0).
//  4. illegal_instr_i forced at cycle 63 (same cycle as limit)
//     -> halted_o=1, timeout_o=0; also check done_o exactly DRAIN_CYCLES+NUM_CHECKS+1 cycles after the halt.
//  5. rstn_i pulsed low during CHECK
//     -> all outputs 0 in the same cycle; a fresh start_i reruns and passes.
//  6. In DONE, pulse start_i (ignored), then clear_i -> IDLE; restart with DRAIN_CYCLES=0 -> correct pass.

Source files
------------

// File: rtl/jedro_1_test_pkg.sv
// Shared types and width helpers for the jedro_1 end-of-test monitor.
package jedro_1_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jedro_1_test_monitor.sv
// End-of-test monitor: runs until illegal instruction or cycle limit, drains,
// then compares a list of register-file entries against expected values.
module jedro_1_test_monitor
  import jedro_1_test_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_CYCLES     = 64,
  parameter int DRAIN_CYCLES   = 3,
  parameter int NUM_CHECKS     = 2,
  parameter int REQUIRE_HALT   = 1,
  localparam int FCW  = $clog2(NUM_CHECKS + 1),
  localparam int IDXW = clog2_min1(NUM_CHECKS),
  localparam int CCW  = $clog2(MAX_CYCLES + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 start_i,
  input  logic                                 clear_i,
  input  logic                                 illegal_instr_i,
  input  logic [NUM_CHECKS*REG_ADDR_WIDTH-1:0] exp_addr_i,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0]     exp_data_i,
  output logic [REG_ADDR_WIDTH-1:0]            reg_addr_o,
  input  logic [DATA_WIDTH-1:0]                reg_data_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 pass_o,
  output logic                                 halted_o,
  output logic                                 timeout_o,
  output logic [FCW-1:0]                       fail_count_o,
  output logic [IDXW-1:0]                      first_fail_idx_o,
  output logic [DATA_WIDTH-1:0]                first_fail_data_o,
  output logic [CCW-1:0]                       cycle_count_o
);

  // One counter serves both the run phase and the drain phase.
  localparam int CNTW = max_int(CCW, clog2_min1(DRAIN_CYCLES + 1));
  localparam logic [CNTW-1:0] RUN_MAX    = CNTW'(MAX_CYCLES);
  localparam logic [CNTW-1:0] RUN_LAST   = CNTW'(MAX_CYCLES - 1);
  localparam logic [CNTW-1:0] DRAIN_LAST = CNTW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [IDXW-1:0] K_LAST     = IDXW'(NUM_CHECKS - 1);

  state_e                    state_r, state_s;
  logic [CNTW-1:0]           cnt_r, cnt_s;
  logic [CCW-1:0]            cycle_count_r, cycle_count_s;
  logic [IDXW-1:0]           k_r, k_s, nk_s;
  logic [FCW-1:0]            fail_count_r, fail_count_s;
  logic [IDXW-1:0]           first_idx_r, first_idx_s;
  logic [DATA_WIDTH-1:0]     first_data_r, first_data_s;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_r, reg_addr_s;
  logic [DATA_WIDTH-1:0]     exp_data_k_s;
  logic                      halted_r, halted_s, timeout_r, timeout_s;
  logic                      pass_r, pass_s, done_r, done_s, busy_r, busy_s;
  logic                      mismatch_s;

  assign exp_data_k_s = exp_data_i[k_r*DATA_WIDTH +: DATA_WIDTH];
  assign nk_s         = (k_r == K_LAST) ? {IDXW{1'b0}} : k_r + IDXW'(1'b1);

  // Next-state and next-result computation for every monitor register.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    cycle_count_s = cycle_count_r;
    k_s           = k_r;
    fail_count_s  = fail_count_r;
    first_idx_s   = first_idx_r;
    first_data_s  = first_data_r;
    reg_addr_s    = reg_addr_r;
    halted_s      = halted_r;
    timeout_s     = timeout_r;
    pass_s        = pass_r;
    done_s        = done_r;
    mismatch_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s       = ST_RUN;
          cnt_s         = {CNTW{1'b0}};
          cycle_count_s = {CCW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_s         = (cnt_r == RUN_MAX) ? cnt_r : cnt_r + CNTW'(1'b1);
        cycle_count_s = CCW'(cnt_s);
        if (illegal_instr_i || (cnt_r == RUN_LAST)) begin
          // Halt takes priority when it coincides with the cycle limit.
          if (illegal_instr_i) begin
            halted_s = 1'b1;
          end else begin
            timeout_s = 1'b1;
          end
          if (DRAIN_CYCLES == 0) begin
            state_s    = ST_CHECK;
            k_s        = {IDXW{1'b0}};
            reg_addr_s = exp_addr_i[0 +: REG_ADDR_WIDTH];
          end else begin
            state_s = ST_DRAIN;
            cnt_s   = {CNTW{1'b0}};
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_s    = ST_CHECK;
          k_s        = {IDXW{1'b0}};
          reg_addr_s = exp_addr_i[0 +: REG_ADDR_WIDTH];
        end else begin
          cnt_s = cnt_r + CNTW'(1'b1);
        end
      end
      ST_CHECK: begin
        mismatch_s = (reg_data_i != exp_data_k_s);
        if (mismatch_s) begin
          fail_count_s = fail_count_r + FCW'(1'b1);
          if (fail_count_r == {FCW{1'b0}}) begin
            first_idx_s  = k_r;
            first_data_s = reg_data_i;
          end else begin
            first_idx_s = first_idx_r;
          end
        end else begin
          fail_count_s = fail_count_r;
        end
        if (k_r == K_LAST) begin
          state_s    = ST_DONE;
          done_s     = 1'b1;
          pass_s     = (fail_count_s == {FCW{1'b0}}) && !((REQUIRE_HALT != 0) && timeout_r);
          reg_addr_s = {REG_ADDR_WIDTH{1'b0}};
        end else begin
          k_s        = nk_s;
          reg_addr_s = exp_addr_i[nk_s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        end
      end
      ST_DONE: begin
        if (clear_i) begin
          state_s       = ST_IDLE;
          cycle_count_s = {CCW{1'b0}};
          fail_count_s  = {FCW{1'b0}};
          first_idx_s   = {IDXW{1'b0}};
          first_data_s  = {DATA_WIDTH{1'b0}};
          halted_s      = 1'b0;
          timeout_s     = 1'b0;
          pass_s        = 1'b0;
          done_s        = 1'b0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s == ST_RUN) || (state_s == ST_DRAIN) || (state_s == ST_CHECK);
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counter, check index and result registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_r         <= {CNTW{1'b0}};
      cycle_count_r <= {CCW{1'b0}};
      k_r           <= {IDXW{1'b0}};
      fail_count_r  <= {FCW{1'b0}};
      first_idx_r   <= {IDXW{1'b0}};
      first_data_r  <= {DATA_WIDTH{1'b0}};
      reg_addr_r    <= {REG_ADDR_WIDTH{1'b0}};
      halted_r      <= 1'b0;
      timeout_r     <= 1'b0;
      pass_r        <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      cnt_r         <= cnt_s;
      cycle_count_r <= cycle_count_s;
      k_r           <= k_s;
      fail_count_r  <= fail_count_s;
      first_idx_r   <= first_idx_s;
      first_data_r  <= first_data_s;
      reg_addr_r    <= reg_addr_s;
      halted_r      <= halted_s;
      timeout_r     <= timeout_s;
      pass_r        <= pass_s;
      done_r        <= done_s;
      busy_r        <= busy_s;
    end
  end

  assign reg_addr_o        = reg_addr_r;
  assign busy_o            = busy_r;
  assign done_o            = done_r;
  assign pass_o            = pass_r;
  assign halted_o          = halted_r;
  assign timeout_o         = timeout_r;
  assign fail_count_o      = fail_count_r;
  assign first_fail_idx_o  = first_idx_r;
  assign first_fail_data_o = first_data_r;
  assign cycle_count_o     = cycle_count_r;

endmodule

// File: tb/tb_jedro_1_test_monitor.sv
// Directed bench for jedro_1_test_monitor with a behavioural register file
// standing in for the core; one instance per drain/halt configuration.
module tb_jedro_1_test_monitor;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, clear, illegal;
  logic        start0, clear0, illegal0;
  logic [9:0]  exp_addr;
  logic [63:0] exp_data;
  logic [31:0] rf [0:31];

  logic [4:0]  reg_addr, reg_addr0;
  logic [31:0] reg_data, reg_data0;
  logic        busy, done, pass, halted, timeout;
  logic        busy0, done0, pass0, halted0, timeout0;
  logic [1:0]  fail_count, fail_count0;
  logic        ffi, ffi0;
  logic [31:0] ffd, ffd0;
  logic [6:0]  cyc, cyc0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign reg_data  = rf[reg_addr];
  assign reg_data0 = rf[reg_addr0];

  jedro_1_test_monitor #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .MAX_CYCLES(64),
    .DRAIN_CYCLES(3), .NUM_CHECKS(2), .REQUIRE_HALT(1)
  ) u_dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .clear_i(clear),
    .illegal_instr_i(illegal), .exp_addr_i(exp_addr), .exp_data_i(exp_data),
    .reg_addr_o(reg_addr), .reg_data_i(reg_data), .busy_o(busy), .done_o(done),
    .pass_o(pass), .halted_o(halted), .timeout_o(timeout),
    .fail_count_o(fail_count), .first_fail_idx_o(ffi),
    .first_fail_data_o(ffd), .cycle_count_o(cyc)
  );

  jedro_1_test_monitor #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .MAX_CYCLES(64),
    .DRAIN_CYCLES(0), .NUM_CHECKS(2), .REQUIRE_HALT(0)
  ) u_dut0 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start0), .clear_i(clear0),
    .illegal_instr_i(illegal0), .exp_addr_i(exp_addr), .exp_data_i(exp_data),
    .reg_addr_o(reg_addr0), .reg_data_i(reg_data0), .busy_o(busy0), .done_o(done0),
    .pass_o(pass0), .halted_o(halted0), .timeout_o(timeout0),
    .fail_count_o(fail_count0), .first_fail_idx_o(ffi0),
    .first_fail_data_o(ffd0), .cycle_count_o(cyc0)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a run on the main instance and raise illegal after `n` run cycles.
  task automatic run_halt(input int n);
    start = 1'b1; tick(1); start = 1'b0;
    tick(n);
    illegal = 1'b1; tick(1); illegal = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    {start, clear, illegal, start0, clear0, illegal0} = 6'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'd0;
    rf[2] = 32'd7;
    exp_addr = {5'd2, 5'd1};
    exp_data = {32'd7, 32'd0};
    tick(2);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cyc", cyc, 7'd0);
    chk("rst_addr", reg_addr, 5'd0);
    rstn = 1'b1;
    tick(1);

    // 1: halt at run cycle 20, both registers match
    start = 1'b1; tick(1); start = 1'b0;
    chk("t1_busy", busy, 1'b1);
    tick(19);
    illegal = 1'b1; tick(1); illegal = 1'b0;
    chk("t1_halted_early", halted, 1'b1);
    tick(3);
    chk("t1_addr_k0", reg_addr, 5'd1);
    chk("t1_notdone", done, 1'b0);
    tick(1);
    chk("t1_addr_k1", reg_addr, 5'd2);
    tick(1);
    chk("t1_done", done, 1'b1);
    chk("t1_pass", pass, 1'b1);
    chk("t1_halted", halted, 1'b1);
    chk("t1_timeout", timeout, 1'b0);
    chk("t1_fails", fail_count, 2'd0);
    chk("t1_cyc", cyc, 7'd20);
    chk("t1_busy_done", busy, 1'b0);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("t1_clr_done", done, 1'b0);
    chk("t1_clr_halted", halted, 1'b0);

    // 2: expected x2=8 but regfile holds 7
    exp_data = {32'd8, 32'd0};
    run_halt(19);
    tick(5);
    chk("t2_done", done, 1'b1);
    chk("t2_pass", pass, 1'b0);
    chk("t2_fails", fail_count, 2'd1);
    chk("t2_ffi", ffi, 1'b1);
    chk("t2_ffd", ffd, 32'd7);
    clear = 1'b1; tick(1); clear = 1'b0;
    exp_data = {32'd7, 32'd0};

    // 3: no halt, cycle limit reached; halt required so it fails
    start = 1'b1; tick(1); start = 1'b0;
    tick(63);
    chk("t3_timeout_pre", timeout, 1'b0);
    chk("t3_cyc_pre", cyc, 7'd63);
    tick(1);
    chk("t3_timeout", timeout, 1'b1);
    chk("t3_halted", halted, 1'b0);
    chk("t3_cyc", cyc, 7'd64);
    tick(5);
    chk("t3_done", done, 1'b1);
    chk("t3_pass", pass, 1'b0);
    chk("t3_fails", fail_count, 2'd0);
    clear = 1'b1; tick(1); clear = 1'b0;

    // 3b: same timeout, halt not required, no drain
    start0 = 1'b1; tick(1); start0 = 1'b0;
    tick(64);
    chk("t3b_timeout", timeout0, 1'b1);
    chk("t3b_notdone", done0, 1'b0);
    tick(2);
    chk("t3b_done", done0, 1'b1);
    chk("t3b_pass", pass0, 1'b1);
    chk("t3b_cyc", cyc0, 7'd64);
    clear0 = 1'b1; tick(1); clear0 = 1'b0;

    // 4: halt coincides with the cycle limit
    run_halt(63);
    chk("t4_halted", halted, 1'b1);
    chk("t4_timeout", timeout, 1'b0);
    chk("t4_cyc", cyc, 7'd64);
    tick(4);
    chk("t4_notdone", done, 1'b0);
    tick(1);
    chk("t4_done", done, 1'b1);
    chk("t4_pass", pass, 1'b1);
    clear = 1'b1; tick(1); clear = 1'b0;

    // 5: reset asserted during CHECK, then a fresh passing run
    run_halt(19);
    tick(3);
    chk("t5_incheck", reg_addr, 5'd1);
    rstn = 1'b0; #1;
    chk("t5_rst_halted", halted, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_addr", reg_addr, 5'd0);
    chk("t5_rst_cyc", cyc, 7'd0);
    tick(1);
    rstn = 1'b1;
    tick(1);
    run_halt(19);
    tick(5);
    chk("t5_done", done, 1'b1);
    chk("t5_pass", pass, 1'b1);

    // 6: start ignored in DONE, clear beats start, then restart with no drain
    start = 1'b1; tick(1); start = 1'b0;
    chk("t6_hold_done", done, 1'b1);
    chk("t6_hold_busy", busy, 1'b0);
    start = 1'b1; clear = 1'b1; tick(1); start = 1'b0; clear = 1'b0;
    tick(1);
    chk("t6_clr_done", done, 1'b0);
    chk("t6_clr_busy", busy, 1'b0);
    start0 = 1'b1; tick(1); start0 = 1'b0;
    tick(19);
    illegal0 = 1'b1; tick(1); illegal0 = 1'b0;
    tick(1);
    chk("t6_notdone", done0, 1'b0);
    tick(1);
    chk("t6_done", done0, 1'b1);
    chk("t6_pass", pass0, 1'b1);
    chk("t6_halted", halted0, 1'b1);
    chk("t6_cyc", cyc0, 7'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
